// File: rtl/fm_tx_pkg.sv
// Shared types and sizing helpers for the FM transmit core.
package fm_tx_pkg;
  localparam int AUDIO_W = 16;

  typedef enum logic [1:0] {IDLE, PRIME, RUN} state_t;

  // Accumulator must hold audio*M: 16-bit signed sample widened by one bit plus log2(M).
  function automatic int acc_width(input int m);
    return 17 + $clog2(m);
  endfunction
endpackage

// File: rtl/dds.sv
// Plain phase accumulator; phase advances by K every clock, cleared by reset.
module dds #(
  parameter int width_dds = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [width_dds-1:0] K,
  output logic [width_dds-1:0] phase
);
  always_ff @(posedge clk) begin
    if (!reset) phase <= '0;
    else        phase <= phase + K;
  end
endmodule

// File: rtl/fm_modulator.sv
// FM transmitter: first-order-hold interpolation of audio by M driving a DDS
// whose frequency word is K plus the scaled interpolated audio.
module fm_modulator
  import fm_tx_pkg::*;
#(
  parameter int width_dds = 32,
  parameter int M         = 7500,
  parameter int dev_shift = 0
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [width_dds-1:0]       K,
  input  logic signed [AUDIO_W-1:0]  audio,
  input  logic                       audio_valid,
  output logic                       audio_ready,
  output logic                       rf,
  output logic [width_dds-1:0]       phase,
  output logic                       underrun
);
  localparam int ACC_W = acc_width(M);
  localparam int CNT_W = (M > 1) ? $clog2(M) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(M - 1);

  state_t                     r_state, w_next;
  logic [CNT_W-1:0]           r_cnt;
  logic signed [AUDIO_W-1:0]  r_cur;
  logic signed [AUDIO_W:0]    r_delta;
  logic signed [ACC_W-1:0]    r_acc;
  logic                       r_underrun, r_rf;

  logic                       w_clr, w_take, w_boundary;
  logic signed [AUDIO_W:0]    w_diff;
  logic signed [width_dds-1:0] w_offset;
  logic [width_dds-1:0]       w_freq, w_phase;

  // IDLE, disable and reset all collapse to the same clear path.
  assign w_clr      = !reset || !enable || (r_state == IDLE);
  assign w_boundary = (r_state == RUN) && (r_cnt == CNT_LAST);
  assign w_take     = enable && audio_valid && audio_ready;
  assign w_diff     = (AUDIO_W+1)'(audio) - (AUDIO_W+1)'(r_cur);

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (!enable) w_next = IDLE;
    else begin
      case (r_state)
        IDLE:    w_next = PRIME;
        PRIME:   if (audio_valid) w_next = RUN;
        RUN:     w_next = RUN;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    audio_ready = (r_state == PRIME) || w_boundary;
  end

  always_ff @(posedge clk) begin
    if (w_clr) begin
      r_cnt      <= '0;
      r_cur      <= '0;
      r_delta    <= '0;
      r_acc      <= '0;
      r_underrun <= 1'b0;
    end else begin
      case (r_state)
        PRIME: if (w_take) begin
          r_delta <= w_diff;
          r_cur   <= audio;
          r_cnt   <= '0;
        end
        RUN: begin
          r_acc <= r_acc + ACC_W'(r_delta);
          if (w_boundary) begin
            r_cnt <= '0;
            if (w_take) begin
              r_delta <= w_diff;
              r_cur   <= audio;
            end else begin
              // Missing sample: freeze the slope so acc settles at cur*M.
              r_delta    <= '0;
              r_underrun <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign w_offset = (r_state == RUN) ? (width_dds'(r_acc) <<< dev_shift) : '0;
  assign w_freq   = K + w_offset;

  dds #(.width_dds(width_dds)) u_dds (
    .clk   (clk),
    .reset (!w_clr),
    .K     (w_freq),
    .phase (w_phase)
  );

  always_ff @(posedge clk) begin
    if (w_clr) r_rf <= 1'b0;
    else       r_rf <= w_phase[width_dds-1];
  end

  assign phase    = w_phase;
  assign rf       = r_rf;
  assign underrun = r_underrun;
endmodule

// File: tb/tb_fm_modulator.sv
// Directed scoreboard bench: stimulus queues hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_fm_modulator;
  logic               clk = 1'b0;
  logic               reset, enable, audio_valid;
  logic [31:0]        K;
  logic signed [15:0] audio;

  logic        rdy0, rf0, ur0, rdy4, rf4, ur4;
  logic [31:0] ph0, ph4;

  typedef struct {
    int          sel;
    logic [31:0] ph;
    logic        rf;
    logic        rdy;
    logic        ur;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   nchecks = 0;
  int   nerr    = 0;

  always #5 clk = ~clk;

  fm_modulator #(.width_dds(32), .M(4), .dev_shift(0)) u0 (
    .clk(clk), .reset(reset), .enable(enable), .K(K), .audio(audio),
    .audio_valid(audio_valid), .audio_ready(rdy0), .rf(rf0), .phase(ph0),
    .underrun(ur0)
  );

  fm_modulator #(.width_dds(32), .M(4), .dev_shift(4)) u4 (
    .clk(clk), .reset(reset), .enable(enable), .K(K), .audio(audio),
    .audio_valid(audio_valid), .audio_ready(rdy4), .rf(rf4), .phase(ph4),
    .underrun(ur4)
  );

  task automatic chk(input string nm, input string fld, input logic [31:0] got, input logic [31:0] want);
    nchecks++;
    if (got !== want) begin
      nerr++;
      $display("FAIL %s.%s got %h want %h", nm, fld, got, want);
    end
  endtask

  // Expectation for outputs right after the next rising edge.
  task automatic step(input int sel, input logic [31:0] ph, input logic rfv,
                      input logic rdy, input logic ur, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    e.sel = sel; e.ph = ph; e.rf = rfv; e.rdy = rdy; e.ur = ur; e.nm = nm;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.sel == 0) begin
        chk(e.nm, "phase", ph0, e.ph);
        chk(e.nm, "rf", {31'b0, rf0}, {31'b0, e.rf});
        chk(e.nm, "ready", {31'b0, rdy0}, {31'b0, e.rdy});
        chk(e.nm, "underrun", {31'b0, ur0}, {31'b0, e.ur});
      end else begin
        chk(e.nm, "phase", ph4, e.ph);
        chk(e.nm, "rf", {31'b0, rf4}, {31'b0, e.rf});
        chk(e.nm, "ready", {31'b0, rdy4}, {31'b0, e.rdy});
        chk(e.nm, "underrun", {31'b0, ur4}, {31'b0, e.ur});
      end
    end
  end

  initial begin
    // Reset held with enable and a pending sample.
    reset = 1'b0; enable = 1'b1; audio_valid = 1'b1; audio = 16'sd1234;
    K = 32'h4000_0000;
    step(0, 32'h0, 0, 0, 0, "rst1");
    step(0, 32'h0, 0, 0, 0, "rst2");
    reset = 1'b1; audio_valid = 1'b0;

    // Carrier only.
    step(0, 32'h0000_0000, 0, 1, 0, "car0");
    step(0, 32'h4000_0000, 0, 1, 0, "car1");
    step(0, 32'h8000_0000, 0, 1, 0, "car2");
    step(0, 32'hC000_0000, 1, 1, 0, "car3");
    step(0, 32'h0000_0000, 1, 1, 0, "car4");
    step(0, 32'h4000_0000, 0, 1, 0, "car5");
    enable = 1'b0; K = 32'h0;
    step(0, 32'h0, 0, 0, 0, "idle");

    // Linear interpolation 100 -> 200.
    enable = 1'b1; audio_valid = 1'b1; audio = 16'sd100;
    step(0, 32'd0, 0, 1, 0, "prime");
    step(0, 32'd0, 0, 0, 0, "acc100_take");
    audio = 16'sd200;
    step(0, 32'd0,    0, 0, 0, "lin1");
    step(0, 32'd100,  0, 0, 0, "lin2");
    step(0, 32'd300,  0, 1, 0, "lin3");
    step(0, 32'd600,  0, 0, 0, "lin4");
    step(0, 32'd1000, 0, 0, 0, "lin5");
    step(0, 32'd1500, 0, 0, 0, "lin6");
    step(0, 32'd2100, 0, 1, 0, "lin7");
    audio_valid = 1'b0;

    // Underrun: acc holds 800, flag sticks through a later sample.
    step(0, 32'd2800, 0, 0, 1, "ur1");
    step(0, 32'd3600, 0, 0, 1, "ur2");
    step(0, 32'd4400, 0, 0, 1, "ur3");
    step(0, 32'd5200, 0, 1, 1, "ur4");
    audio_valid = 1'b1; audio = 16'sd300;
    step(0, 32'd6000, 0, 0, 1, "ur5");
    audio_valid = 1'b0;
    step(0, 32'd6800, 0, 0, 1, "ur6");
    step(0, 32'd7700, 0, 0, 1, "ur7");

    // Disable at cnt=2 with a sample offered.
    enable = 1'b0; audio_valid = 1'b1; audio = 16'sd500;
    step(0, 32'd0, 0, 0, 0, "dis");
    enable = 1'b1; audio = 16'sd50;
    step(0, 32'd0, 0, 1, 0, "re_prime");
    step(0, 32'd0, 0, 0, 0, "re_take");
    audio_valid = 1'b0;
    step(0, 32'd0,   0, 0, 0, "re1");
    step(0, 32'd50,  0, 0, 0, "re2");
    step(0, 32'd150, 0, 1, 0, "re3");

    // Negative full-scale with dev_shift=4 and a near-zero-wrapping K.
    enable = 1'b0; K = 32'hFFFF_FFF0;
    step(1, 32'h0, 0, 0, 0, "neg_idle");
    enable = 1'b1; audio_valid = 1'b1; audio = -16'sd32768;
    step(1, 32'h0000_0000, 0, 1, 0, "neg_prime");
    step(1, 32'hFFFF_FFF0, 0, 0, 0, "neg0");
    audio_valid = 1'b0;
    step(1, 32'hFFFF_FFE0, 1, 0, 0, "neg1");
    step(1, 32'hFFF7_FFD0, 1, 0, 0, "neg2");
    step(1, 32'hFFE7_FFC0, 1, 1, 0, "neg3");
    step(1, 32'hFFCF_FFB0, 1, 0, 1, "neg4");
    step(1, 32'hFFAF_FFA0, 1, 0, 1, "neg5");

    repeat (2) @(negedge clk);
    #1;
    nchecks++;
    if (sb.size() != 0) begin
      nerr++;
      $display("FAIL drain got %0d want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
    $finish;
  end
endmodule
